// File: rtl/router_out_arbiter_pkg.sv
// Shared router types: flit-type encodings, default port count and flit width,
// arbiter FSM state, and a helper that recognises packet-ending flits.
package router_pkg;

  localparam int NPORT = 5;
  localparam int DW    = 35;

  typedef logic [1:0] flit_type_t;

  localparam flit_type_t FLIT_BODY = 2'b00;
  localparam flit_type_t FLIT_HEAD = 2'b01;
  localparam flit_type_t FLIT_TAIL = 2'b10;
  localparam flit_type_t FLIT_HT   = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_e;

  function automatic logic is_tail(input flit_type_t t);
    return (t == FLIT_TAIL) || (t == FLIT_HT);
  endfunction

endpackage

// File: rtl/router_out_arbiter_if.sv
// Request/flit bundle between the input ports and one output arbiter.
// slave = arbiter side, master = upstream ports plus downstream readiness.
interface router_out_arbiter_if #(
  parameter int NPORT = router_pkg::NPORT,
  parameter int DW    = router_pkg::DW
);

  logic [NPORT-1:0]    IREQ;
  logic [NPORT*DW-1:0] IDATA;
  logic [NPORT-1:0]    IVALID;
  logic [NPORT-1:0]    IVCH;
  logic [NPORT-1:0]    OACK;
  logic [DW-1:0]       ODATA;
  logic                OVALID;
  logic                OVCH;
  logic [1:0]          IRDY;
  logic [NPORT-1:0]    OGNT;
  logic                OBUSY;

  modport master (
    output IREQ, IDATA, IVALID, IVCH, IRDY,
    input  OACK, ODATA, OVALID, OVCH, OGNT, OBUSY
  );

  modport slave (
    input  IREQ, IDATA, IVALID, IVCH, IRDY,
    output OACK, ODATA, OVALID, OVCH, OGNT, OBUSY
  );

endinterface

// File: rtl/router_out_arbiter_rr_pick.sv
// Combinational round-robin selector: one-hot of the first requester at or
// after ptr_i, wrapping modulo N; all-zero when nothing requests.
module rr_pick #(
  parameter int N  = 5,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr_i) + k) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Output-port allocator + flit mux: 1-cycle arbitration, packet-long grant, 1-cycle output register.
// Per-VC IRDY stalls the granted port; ROUTER_ARB_WDOG_EN adds a stall watchdog that forces release.
module router_out_arbiter #(
  parameter int NPORT = router_pkg::NPORT,
  parameter int DW    = router_pkg::DW
`ifdef ROUTER_ARB_WDOG_EN
  ,
  parameter int TMO_CYC = 255
`endif
) (
  input logic                 clk,
  input logic                 RST_,
  router_out_arbiter_if.slave bus
);

  import router_pkg::*;

  localparam int PW = $clog2(NPORT);

  arb_state_e       state_q, state_d;
  logic [NPORT-1:0] gnt_q, gnt_d, pick;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d, gidx;
  logic [DW-1:0]    odata_q, odata_d, g_dat;
  logic             ovalid_q, ovalid_d, ovch_q, ovch_d;
  logic             g_vld, g_vch, xfer, tail_xfer, rel;

  rr_pick #(.N(NPORT), .PW(PW)) u_pick (
    .req_i (bus.IREQ),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    gidx = '0;
    for (int k = 0; k < NPORT; k++) begin
      if (gnt_q[k]) gidx = PW'(k);
    end
  end

  assign g_dat     = bus.IDATA[int'(gidx)*DW +: DW];
  assign g_vld     = bus.IVALID[gidx];
  assign g_vch     = bus.IVCH[gidx];
  assign xfer      = (state_q == ST_LOCK) && g_vld && bus.IRDY[g_vch];
  assign tail_xfer = xfer && is_tail(flit_type_t'(g_dat[DW-1 -: 2]));

`ifdef ROUTER_ARB_WDOG_EN
  localparam int WDW = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;

  logic [WDW-1:0] wdog_q, wdog_d;
  logic           tmo;

  // Fires in the stall cycle that would bring the count up to TMO_CYC.
  assign tmo = (state_q == ST_LOCK) && !xfer && (wdog_q == WDW'(TMO_CYC - 1));
  assign rel = tail_xfer || tmo;

  always_comb begin
    wdog_d = '0;
    if (state_q == ST_LOCK && !xfer && !tmo) wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  assign rel = tail_xfer;
`endif

  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|bus.IREQ) state_d = ST_LOCK;
      ST_LOCK: if (rel)       state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE) begin
      gnt_d = pick;
    end else if (rel) begin
      gnt_d    = '0;
      rr_ptr_d = (gidx == PW'(NPORT - 1)) ? '0 : gidx + 1'b1;
    end
    ovalid_d = xfer;
    odata_d  = xfer ? g_dat : odata_q;
    ovch_d   = xfer ? g_vch : ovch_q;
    bus.OACK = xfer ? gnt_q : '0;
  end

  always_ff @(posedge clk or negedge RST_) begin
    if (!RST_) begin
      gnt_q    <= '0;
      rr_ptr_q <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      ovch_q   <= 1'b0;
    end else begin
      gnt_q    <= gnt_d;
      rr_ptr_q <= rr_ptr_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      ovch_q   <= ovch_d;
    end
  end

  assign bus.OGNT   = gnt_q;
  assign bus.OBUSY  = (state_q == ST_LOCK);
  assign bus.ODATA  = odata_q;
  assign bus.OVALID = ovalid_q;
  assign bus.OVCH   = ovch_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: single packet, contention, VC backpressure,
// request drop, async reset and (with ROUTER_ARB_WDOG_EN, TMO_CYC=4) watchdog release.
module tb_router_out_arbiter;

  import router_pkg::*;

  logic clk = 1'b0;
  logic RST_;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  router_out_arbiter_if #(.NPORT(NPORT), .DW(DW)) bus ();

`ifdef ROUTER_ARB_WDOG_EN
  router_out_arbiter #(.NPORT(NPORT), .DW(DW), .TMO_CYC(4)) dut (
    .clk (clk), .RST_ (RST_), .bus (bus)
  );
`else
  router_out_arbiter #(.NPORT(NPORT), .DW(DW)) dut (
    .clk (clk), .RST_ (RST_), .bus (bus)
  );
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [DW-1:0] fl(input flit_type_t t, input int tag);
    return {t, (DW-2)'(tag)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input int p, input flit_type_t t, input int tag, input logic vc);
    bus.IREQ[p]              = 1'b1;
    bus.IVALID[p]            = 1'b1;
    bus.IVCH[p]              = vc;
    bus.IDATA[p*DW +: DW]    = fl(t, tag);
  endtask

  task automatic quit(input int p);
    bus.IREQ[p]   = 1'b0;
    bus.IVALID[p] = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [DW-1:0] want);
    check_eq({tag, "_vld"}, 64'(bus.OVALID), 64'd1);
    check_eq({tag, "_dat"}, 64'(bus.ODATA), 64'(want));
  endtask

  task automatic chk_zero(input string tag);
    check_eq({tag, "_gnt"},  64'(bus.OGNT),   64'd0);
    check_eq({tag, "_busy"}, 64'(bus.OBUSY),  64'd0);
    check_eq({tag, "_vld"},  64'(bus.OVALID), 64'd0);
    check_eq({tag, "_dat"},  64'(bus.ODATA),  64'd0);
    check_eq({tag, "_vch"},  64'(bus.OVCH),   64'd0);
    check_eq({tag, "_ack"},  64'(bus.OACK),   64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL tb_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [NPORT-1:0] order_gnt [3];
    int               order_port[3];
    order_gnt  = '{5'b00001, 5'b00010, 5'b10000};
    order_port = '{0, 1, 4};

    RST_       = 1'b0;
    bus.IREQ   = '0;
    bus.IDATA  = '0;
    bus.IVALID = '0;
    bus.IVCH   = '0;
    bus.IRDY   = 2'b11;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #3;
    RST_ = 1'b1;

    // Single packet on port 2, then rr_ptr=3 shown by ports 1 and 3 competing.
    tick(); drive(2, FLIT_HEAD, 'h21, 1'b0); settle();
    check_eq("t1_arb_ack", 64'(bus.OACK), 64'd0);
    check_eq("t1_arb_busy", 64'(bus.OBUSY), 64'd0);
    tick(); settle();
    check_eq("t1_gnt", 64'(bus.OGNT), 64'b00100);
    check_eq("t1_busy", 64'(bus.OBUSY), 64'd1);
    check_eq("t1_ack_head", 64'(bus.OACK), 64'b00100);
    check_eq("t1_novld", 64'(bus.OVALID), 64'd0);
    tick(); drive(2, FLIT_BODY, 'h22, 1'b0); settle();
    chk_out("t1_head", fl(FLIT_HEAD, 'h21));
    check_eq("t1_ack_body", 64'(bus.OACK), 64'b00100);
    tick(); drive(2, FLIT_TAIL, 'h23, 1'b0); settle();
    chk_out("t1_body", fl(FLIT_BODY, 'h22));
    tick(); quit(2); settle();
    chk_out("t1_tail", fl(FLIT_TAIL, 'h23));
    check_eq("t1_rel_busy", 64'(bus.OBUSY), 64'd0);
    check_eq("t1_rel_gnt", 64'(bus.OGNT), 64'd0);
    drive(1, FLIT_HT, 'h31, 1'b0); drive(3, FLIT_HT, 'h33, 1'b0); settle();
    tick(); settle();
    check_eq("t1_rrptr3_gnt", 64'(bus.OGNT), 64'b01000);
    check_eq("t1_idle_gap", 64'(bus.OVALID), 64'd0);
    tick(); quit(3); settle();
    chk_out("t1_ht3", fl(FLIT_HT, 'h33));
    tick(); settle();
    check_eq("t1_wrap_gnt1", 64'(bus.OGNT), 64'b00010);
    tick(); quit(1); settle();
    chk_out("t1_ht1", fl(FLIT_HT, 'h31));

    // Contention: reset puts rr_ptr at 0, then ports 0, 1, 4 each send 2 flits.
    RST_ = 1'b0; #2; RST_ = 1'b1;
    drive(0, FLIT_HEAD, 'h40, 1'b0);
    drive(1, FLIT_HEAD, 'h41, 1'b0);
    drive(4, FLIT_HEAD, 'h44, 1'b0);
    settle();
    for (int i = 0; i < 3; i++) begin
      int w;
      w = order_port[i];
      check_eq("t2_arb_ack", 64'(bus.OACK), 64'd0);
      tick(); settle();
      check_eq("t2_gnt", 64'(bus.OGNT), 64'(order_gnt[i]));
      check_eq("t2_idle_gap", 64'(bus.OVALID), 64'd0);
      tick(); drive(w, FLIT_TAIL, 'h50 + w, 1'b0); settle();
      chk_out("t2_head", fl(FLIT_HEAD, 'h40 + w));
      tick(); quit(w); settle();
      chk_out("t2_tail", fl(FLIT_TAIL, 'h50 + w));
      check_eq("t2_rel_busy", 64'(bus.OBUSY), 64'd0);
    end

    // VC1 backpressure on port 0.
    drive(0, FLIT_HT, 'h60, 1'b1); bus.IRDY = 2'b01; settle();
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      check_eq("t3_stall_ack", 64'(bus.OACK), 64'd0);
      check_eq("t3_stall_vld", 64'(bus.OVALID), 64'd0);
    end
    tick(); bus.IRDY = 2'b11; settle();
    check_eq("t3_stall_vld_last", 64'(bus.OVALID), 64'd0);
    check_eq("t3_ack", 64'(bus.OACK), 64'b00001);
    tick(); quit(0); settle();
    chk_out("t3_flit", fl(FLIT_HT, 'h60));
    check_eq("t3_vch", 64'(bus.OVCH), 64'd1);

    // Port 3 drops IREQ mid-packet; port 4 stays blocked until port 3's tail.
    drive(3, FLIT_HEAD, 'h73, 1'b0); drive(4, FLIT_HT, 'h74, 1'b0); settle();
    tick(); settle();
    check_eq("t4_gnt", 64'(bus.OGNT), 64'b01000);
    tick(); quit(3); settle();
    chk_out("t4_head", fl(FLIT_HEAD, 'h73));
    check_eq("t4_held_gnt", 64'(bus.OGNT), 64'b01000);
    check_eq("t4_blocked_ack", 64'(bus.OACK), 64'd0);
    tick(); settle();
    check_eq("t4_held_busy", 64'(bus.OBUSY), 64'd1);
    check_eq("t4_held_gnt2", 64'(bus.OGNT), 64'b01000);
    tick(); drive(3, FLIT_TAIL, 'h83, 1'b0); bus.IREQ[3] = 1'b0; settle();
    check_eq("t4_tail_ack", 64'(bus.OACK), 64'b01000);
    tick(); quit(3); settle();
    chk_out("t4_tail", fl(FLIT_TAIL, 'h83));
    tick(); settle();
    check_eq("t4_next_gnt", 64'(bus.OGNT), 64'b10000);
    tick(); quit(4); settle();
    chk_out("t4_ht4", fl(FLIT_HT, 'h74));

    // Async reset mid-packet on port 3 (rr_ptr=2 beforehand).
    drive(1, FLIT_HT, 'h91, 1'b0); settle();
    tick(); settle();
    check_eq("t5_ack1", 64'(bus.OACK), 64'b00010);
    tick(); quit(1); drive(3, FLIT_HEAD, 'h93, 1'b0); settle();
    tick(); settle();
    check_eq("t5_gnt3", 64'(bus.OGNT), 64'b01000);
    tick(); drive(3, FLIT_BODY, 'h94, 1'b0); settle();
    chk_out("t5_head", fl(FLIT_HEAD, 'h93));
    #1; RST_ = 1'b0; #1;
    chk_zero("t5_async");
    #1; RST_ = 1'b1;
    quit(3);
    drive(1, FLIT_HT, 'hA1, 1'b0); drive(3, FLIT_HT, 'hA3, 1'b0);
    tick(); settle();
    check_eq("t5_restart_gnt", 64'(bus.OGNT), 64'b00010);
    tick(); quit(1); quit(3); settle();
    chk_out("t5_ht1", fl(FLIT_HT, 'hA1));

    // Port 2 granted but never valid; port 4 waits behind it (rr_ptr=2).
    drive(4, FLIT_HT, 'hB4, 1'b0);
    bus.IREQ[2] = 1'b1; bus.IVALID[2] = 1'b0; settle();
    tick(); settle();
    check_eq("t6_gnt2", 64'(bus.OGNT), 64'b00100);
    check_eq("t6_ack", 64'(bus.OACK), 64'd0);
    tick(); tick(); tick(); settle();
    check_eq("t6_stall4_gnt", 64'(bus.OGNT), 64'b00100);
    check_eq("t6_stall4_busy", 64'(bus.OBUSY), 64'd1);
`ifdef ROUTER_ARB_WDOG_EN
    tick(); settle();
    check_eq("t6_forced_busy", 64'(bus.OBUSY), 64'd0);
    check_eq("t6_forced_gnt", 64'(bus.OGNT), 64'd0);
    check_eq("t6_forced_novld", 64'(bus.OVALID), 64'd0);
    tick(); settle();
    check_eq("t6_next_gnt4", 64'(bus.OGNT), 64'b10000);
    tick(); quit(4); quit(2); settle();
    chk_out("t6_ht4", fl(FLIT_HT, 'hB4));
`else
    repeat (4) tick();
    settle();
    check_eq("t6_lock_persists_gnt", 64'(bus.OGNT), 64'b00100);
    check_eq("t6_lock_persists_ack", 64'(bus.OACK), 64'd0);
    quit(4); quit(2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Output-port switch allocator and flit mux for the 5-port, 2-VC mesh router. Up to five input ports compete for one output port. The block grants one at a time, round-robin, and holds the grant for a whole packet (head to tail). It forwards the granted port's flits through a one-stage output register, subject to per-VC downstream readiness. One instance sits in front of each `ODATA_n`/`OVALID_n`/`OVCH_n` output group.

## Interface
- `NPORT`, 5, number of requesting input ports
- `DW`, 35, flit width; bits [34:33] carry the flit type
- `TMO_CYC`, 255, stall-watchdog limit in cycles; used only with `ROUTER_ARB_WDOG_EN`

- `clk` in 1: rising-edge clock
- `RST_` in 1: asynchronous, active-low reset
- `IREQ` in NPORT: per-port request for this output, level, held until tail accepted
- `IDATA` in NPORT*DW: flattened flits; port i at [i*DW +: DW]
- `IVALID` in NPORT: flit on port i valid
- `IVCH` in NPORT: VC of port i's flit
- `OACK` out NPORT: combinational; flit on port i accepted this cycle
- `ODATA` out DW: registered output flit
- `OVALID` out 1: registered output valid
- `OVCH` out 1: registered output VC
- `IRDY` in 2: downstream can accept a flit on VC0/VC1
- `OGNT` out NPORT: registered one-hot current grant
- `OBUSY` out 1: registered; high while the grant is locked

## Operation
- Flit types: 2'b01 HEAD, 2'b00 BODY, 2'b10 TAIL, 2'b11 HEAD_TAIL (single-flit packet).
- FSM states: IDLE and LOCK.
- **IDLE**
  - If any `IREQ` is set, select the first requester at or after `rr_ptr`, wrapping modulo NPORT.
  - Next cycle: `OGNT` = one-hot of the winner, `OBUSY`=1, state LOCK.
  - No flit transfers in the arbitration cycle.
- **LOCK**, with granted port g:
  - Transfer condition: `IVALID[g] && IRDY[IVCH[g]]`.
  - On transfer: `OACK[g]`=1 (combinational); next edge `ODATA`=`IDATA[g]`, `OVCH`=`IVCH[g]`, `OVALID`=1.
  - Without a transfer, `OVALID`=0 next cycle.
  - Every `OACK` bit for a port ≠ g is 0.
- **Release:** on transfer of a TAIL or HEAD_TAIL flit:
  - state→IDLE, `OGNT`=0, `OBUSY`=0;
  - `rr_ptr`=(g+1) mod NPORT.
- `rr_ptr` changes only on release, so a port that wins waits behind every other active requester before winning again.
- If `IREQ[g]` drops while locked, the grant is held anyway. Only the tail releases it (or the watchdog, when built in).
- Non-HEAD first flit: forward it unchanged. The arbiter does not check protocol.

## Timing
- Reset values: `ODATA`=0, `OVALID`=0, `OVCH`=0, `OGNT`=0, `OBUSY`=0, `rr_ptr`=0, state IDLE, watchdog count 0.
- Latency:
  - 1 cycle from request in IDLE to grant.
  - 1 cycle from accepted input flit to `ODATA`.
  - First flit of a packet requested at cycle t appears at t+2 at the earliest.
- Throughput: one flit per cycle while `IRDY[vch]` is held high.
- Back-to-back packets: release and re-arbitration cost exactly one idle output cycle.
- `IRDY` may change any cycle. A flit counts as transferred only in a cycle where `OACK` is high.
- Reset mid-packet clears the lock immediately. Upstream must resend the packet from its head.

## Configuration
- `ROUTER_ARB_WDOG_EN` defined:
  - An 8-bit-minimum counter increments each LOCK cycle without a transfer and clears on any transfer.
  - On reaching `TMO_CYC`, force release: `rr_ptr`=g+1, no flit emitted.
- `ROUTER_ARB_WDOG_EN` undefined: no counter logic; a lock persists indefinitely.

## Structure
- Shared package `router_pkg`:
  - flit-type constants `FLIT_HEAD`, `FLIT_BODY`, `FLIT_TAIL`, `FLIT_HT`;
  - `DW`, `NPORT`;
  - FSM state typedef.
- Sub-module `rr_pick`: combinational round-robin priority selector (req vector, ptr → one-hot).

## Test plan
- **Single packet:** port 2 sends HEAD, BODY, TAIL with `IRDY`=2'b11. Required: `OGNT`=5'b00100 at t+1, `ODATA` flits at t+2..t+4, then `OBUSY`=0 and `rr_ptr`=3.
- **Contention:** ports 0, 1, 4 request simultaneously with `rr_ptr`=0, each sending a 2-flit packet. Required: grant order 0, 1, 4, with one idle cycle between packets.
- **VC backpressure:** granted flits on VC1 with `IRDY`=2'b01 for 3 cycles. Required: `OACK`=0 and `OVALID`=0 for those cycles; the flit appears the cycle after `IRDY[1]` rises.
- **Request drop:** port 3 drops `IREQ` mid-packet. Required: grant held and other requesters blocked until port 3's TAIL is accepted.
- **Async reset:** assert `RST_` low mid-packet. Required: all outputs zero immediately, without waiting for a clock edge; after release, arbitration restarts at port 0.
- **Watchdog** (`ROUTER_ARB_WDOG_EN`, `TMO_CYC`=4): granted port stalls with `IVALID`=0. Required: forced release after 4 stall cycles, and the next requester is granted.
